uart_receiver: RTL and testbench

Configurable UART receiver for the peripheral UART block. It takes a serial line sampled at 8× the baud rate via a clock-enable tick. It frames 6–9 data bits with optional even/odd parity and 1 or 2 stop bits. It presents the received word right-justified with a valid/acknowledge handshake plus overrun and parity error flags.

---
 rtl/uart_receiver.sv | 221 ++++++++++++++++++++++
 tb/tb_uart_receiver.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// UART receiver with oversampled bit timing, 6-9 data bits, optional
// even/odd parity and one or two stop bits. Words are presented
// right-justified with a valid/ack handshake plus overrun and parity flags.
module uart_receiver #(
  parameter int OVERSAMPLE = 8
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_ce,
  input  logic [1:0] i_length,
  input  logic       i_stop2,
  input  logic       i_parity,
  input  logic       i_odd,
  input  logic       i_rx,
  input  logic       i_ack,
  output logic [8:0] o_data,
  output logic       o_valid,
  output logic       o_busy,
  output logic       o_overrun_err,
  output logic       o_parity_err
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] HALF_LAST = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP1  = 3'd4,
    STOP2  = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [CW-1:0] tickCnt_q, tickCnt_d;
  logic [3:0]  bitIdx_q, bitIdx_d;
  logic [8:0]  shiftReg_q, shiftReg_d;
  logic        parBit_q, parBit_d;
  logic [1:0]  length_q, length_d;
  logic        stop2_q, stop2_d;
  logic        parityEn_q, parityEn_d;
  logic        odd_q, odd_d;
  logic [8:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        overrun_q, overrun_d;
  logic        parErr_q, parErr_d;
  logic        rxMeta_q, rxSync_q;
  logic [3:0]  lastIdx;
  logic        complete;

  // Two-flop synchronizer for the asynchronous serial line, idles high
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      rxMeta_q <= 1'b1;
      rxSync_q <= 1'b1;
    end else begin
      rxMeta_q <= i_rx;
      rxSync_q <= rxMeta_q;
    end
  end

  // FSM state register; reset aborts any frame in progress
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Frame datapath and output registers
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      tickCnt_q  <= '0;
      bitIdx_q   <= '0;
      shiftReg_q <= '0;
      parBit_q   <= 1'b0;
      length_q   <= '0;
      stop2_q    <= 1'b0;
      parityEn_q <= 1'b0;
      odd_q      <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      overrun_q  <= 1'b0;
      parErr_q   <= 1'b0;
    end else begin
      tickCnt_q  <= tickCnt_d;
      bitIdx_q   <= bitIdx_d;
      shiftReg_q <= shiftReg_d;
      parBit_q   <= parBit_d;
      length_q   <= length_d;
      stop2_q    <= stop2_d;
      parityEn_q <= parityEn_d;
      odd_q      <= odd_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      overrun_q  <= overrun_d;
      parErr_q   <= parErr_d;
    end
  end

  // Index of the final data bit for the frame's latched length code
  always_comb begin
    lastIdx = 4'd7;
    case (length_q)
      2'd0: lastIdx = 4'd7;
      2'd1: lastIdx = 4'd8;
      2'd2: lastIdx = 4'd6;
      2'd3: lastIdx = 4'd5;
      default: lastIdx = 4'd7;
    endcase
  end

  // Next-state and datapath updates; sampling only happens on ticks,
  // while the ack handshake is serviced on every clock
  always_comb begin
    state_d    = state_q;
    tickCnt_d  = tickCnt_q;
    bitIdx_d   = bitIdx_q;
    shiftReg_d = shiftReg_q;
    parBit_d   = parBit_q;
    length_d   = length_q;
    stop2_d    = stop2_q;
    parityEn_d = parityEn_q;
    odd_d      = odd_q;
    data_d     = data_q;
    valid_d    = valid_q;
    overrun_d  = overrun_q;
    parErr_d   = parErr_q;
    complete   = 1'b0;

    if (i_ce) begin
      case (state_q)
        IDLE: begin
          if (!rxSync_q) begin
            state_d    = START;
            tickCnt_d  = '0;
            bitIdx_d   = '0;
            shiftReg_d = '0;
            length_d   = i_length;
            stop2_d    = i_stop2;
            parityEn_d = i_parity;
            odd_d      = i_odd;
          end
        end
        START: begin
          if (tickCnt_q == HALF_LAST) begin
            tickCnt_d = '0;
            state_d   = rxSync_q ? IDLE : DATA;
          end else begin
            tickCnt_d = tickCnt_q + 1'b1;
          end
        end
        DATA: begin
          if (tickCnt_q == FULL_LAST) begin
            tickCnt_d            = '0;
            shiftReg_d[bitIdx_q] = rxSync_q;
            if (bitIdx_q == lastIdx) begin
              state_d = parityEn_q ? PARITY : STOP1;
            end else begin
              bitIdx_d = bitIdx_q + 4'd1;
            end
          end else begin
            tickCnt_d = tickCnt_q + 1'b1;
          end
        end
        PARITY: begin
          if (tickCnt_q == FULL_LAST) begin
            tickCnt_d = '0;
            parBit_d  = rxSync_q;
            state_d   = STOP1;
          end else begin
            tickCnt_d = tickCnt_q + 1'b1;
          end
        end
        STOP1: begin
          if (tickCnt_q == FULL_LAST) begin
            tickCnt_d = '0;
            if (stop2_q) begin
              state_d = STOP2;
            end else begin
              complete = 1'b1;
            end
          end else begin
            tickCnt_d = tickCnt_q + 1'b1;
          end
        end
        STOP2: begin
          if (tickCnt_q == FULL_LAST) begin
            tickCnt_d = '0;
            complete  = 1'b1;
          end else begin
            tickCnt_d = tickCnt_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    if (complete) begin
      state_d   = IDLE;
      data_d    = shiftReg_q;
      parErr_d  = parityEn_q & ((^shiftReg_q ^ parBit_q) != odd_q);
      overrun_d = valid_q & ~i_ack;
      valid_d   = 1'b1;
    end else if (i_ack) begin
      valid_d = 1'b0;
    end
  end

  assign o_data        = data_q;
  assign o_valid       = valid_q;
  assign o_busy        = (state_q != IDLE);
  assign o_overrun_err = overrun_q;
  assign o_parity_err  = parErr_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: directed frames followed by
// randomized frames compared against a word-level reference model.
module tb_uart_receiver;

  logic       i_clk;
  logic       i_rst;
  logic       i_ce;
  logic [1:0] i_length;
  logic       i_stop2;
  logic       i_parity;
  logic       i_odd;
  logic       i_rx;
  logic       i_ack;
  logic [8:0] o_data;
  logic       o_valid;
  logic       o_busy;
  logic       o_overrun_err;
  logic       o_parity_err;

  int checks   = 0;
  int failures = 0;
  bit ceToggle = 1'b0;

  logic [8:0] expData;
  logic       expValid;
  logic       expOvr;
  logic       expPar;

  uart_receiver #(.OVERSAMPLE(8)) dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_ce(i_ce),
    .i_length(i_length),
    .i_stop2(i_stop2),
    .i_parity(i_parity),
    .i_odd(i_odd),
    .i_rx(i_rx),
    .i_ack(i_ack),
    .o_data(o_data),
    .o_valid(o_valid),
    .o_busy(o_busy),
    .o_overrun_err(o_overrun_err),
    .o_parity_err(o_parity_err)
  );

  // Free-running system clock
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Oversample tick: every clock, or every other clock when ceToggle is set
  initial begin
    i_ce = 1'b1;
    forever begin
      @(posedge i_clk);
      #1;
      i_ce = ceToggle ? ~i_ce : 1'b1;
    end
  end

  task automatic checkOutput(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".data"},    o_data,                expData);
    checkOutput({tag, ".valid"},   {8'd0, o_valid},       {8'd0, expValid});
    checkOutput({tag, ".overrun"}, {8'd0, o_overrun_err}, {8'd0, expOvr});
    checkOutput({tag, ".parity"},  {8'd0, o_parity_err},  {8'd0, expPar});
    checkOutput({tag, ".busy"},    {8'd0, o_busy},        9'd0);
  endtask

  task automatic holdBit(input logic b, input int n);
    i_rx = b;
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  // Sends one serial frame and updates the reference model with the
  // word, parity verdict and overrun the receiver should report for it
  task automatic applyStimulus(input logic [8:0] word, input logic [1:0] len,
                               input logic s2, input logic par, input logic odd,
                               input logic flip, input int cpb);
    int nb;
    logic [8:0] masked;
    logic p;
    nb = (len == 2'd0) ? 8 : (len == 2'd1) ? 9 : (len == 2'd2) ? 7 : 6;
    masked = word & 9'((1 << nb) - 1);
    p = ($countones(masked) % 2 == 1) ^ odd ^ flip;
    i_length = len;
    i_stop2  = s2;
    i_parity = par;
    i_odd    = odd;
    holdBit(1'b0, cpb);
    i_length = 2'($urandom);
    i_stop2  = 1'($urandom);
    i_parity = 1'($urandom);
    i_odd    = 1'($urandom);
    for (int i = 0; i < nb; i++) holdBit(masked[i], cpb);
    if (par) holdBit(p, cpb);
    holdBit(1'b1, cpb);
    if (s2) holdBit(1'b1, cpb);
    holdBit(1'b1, 2);
    expOvr   = expValid;
    expValid = 1'b1;
    expData  = masked;
    expPar   = par ? ((($countones(masked) + int'(p)) % 2 == 1) != odd) : 1'b0;
  endtask

  task automatic ackWord();
    i_ack = 1'b1;
    @(posedge i_clk);
    #1;
    i_ack = 1'b0;
    expValid = 1'b0;
  endtask

  initial begin
    int cpb;
    i_rst = 1'b0;
    i_rx = 1'b1;
    i_ack = 1'b0;
    i_length = 2'd0;
    i_stop2 = 1'b0;
    i_parity = 1'b0;
    i_odd = 1'b0;
    expData = 9'd0;
    expValid = 1'b0;
    expOvr = 1'b0;
    expPar = 1'b0;

    $display("[TB] reset and idle");
    repeat (5) @(posedge i_clk);
    #1;
    checkAll("reset");
    i_rst = 1'b1;
    repeat (400) @(posedge i_clk);
    #1;
    checkAll("idle400");

    $display("[TB] 8N1 0x81");
    applyStimulus(9'h081, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8);
    checkAll("8n1");
    ackWord();
    checkAll("8n1.ack");

    $display("[TB] 9-bit even parity, two stop bits");
    applyStimulus(9'h1A5, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 8);
    checkAll("9e2");
    ackWord();
    applyStimulus(9'h1A5, 2'd1, 1'b1, 1'b1, 1'b0, 1'b1, 8);
    checkAll("9e2.bad");
    checkOutput("9e2.bad.flag", {8'd0, o_parity_err}, 9'd1);
    ackWord();

    $display("[TB] 6-bit odd parity");
    applyStimulus(9'h02D, 2'd3, 1'b0, 1'b1, 1'b1, 1'b0, 8);
    checkAll("6o1");
    ackWord();

    $display("[TB] overrun");
    applyStimulus(9'h055, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8);
    applyStimulus(9'h0C3, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8);
    checkAll("ovr");
    checkOutput("ovr.flag", {8'd0, o_overrun_err}, 9'd1);
    ackWord();
    checkAll("ovr.ack");

    $display("[TB] false start");
    holdBit(1'b0, 2);
    holdBit(1'b1, 30);
    checkAll("glitch");

    $display("[TB] gated ticks");
    ceToggle = 1'b1;
    holdBit(1'b1, 4);
    applyStimulus(9'h081, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16);
    checkAll("cegate");
    ackWord();
    ceToggle = 1'b0;
    holdBit(1'b1, 4);

    $display("[TB] reset mid-frame");
    i_length = 2'd0;
    i_parity = 1'b0;
    i_stop2 = 1'b0;
    holdBit(1'b0, 8);
    holdBit(1'b1, 8);
    holdBit(1'b0, 8);
    i_rst = 1'b0;
    i_rx = 1'b1;
    repeat (2) @(posedge i_clk);
    #1;
    expData = 9'd0;
    expValid = 1'b0;
    expOvr = 1'b0;
    expPar = 1'b0;
    checkAll("midreset");
    i_rst = 1'b1;
    holdBit(1'b1, 100);
    checkAll("midreset.idle");

    $display("[TB] randomized frames");
    for (int f = 0; f < 24; f++) begin
      ceToggle = 1'($urandom_range(0, 1));
      cpb = ceToggle ? 16 : 8;
      holdBit(1'b1, 4);
      applyStimulus(9'($urandom), 2'($urandom), 1'($urandom), 1'($urandom),
                    1'($urandom), 1'($urandom_range(0, 3) == 0), cpb);
      checkAll($sformatf("rnd%0d", f));
      if ($urandom_range(0, 2) != 0) ackWord();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
